// File: rtl/seq_comp.sv
`default_nettype none
// =============================================================================
// seq_comp : chunk-serial magnitude comparator, MSB slice first, early exit.
// Rev 1.0 -- define SEQ_COMP_SIGNED_EN to add signed_mode (two's-complement).
// =============================================================================
module seq_comp #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_COMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             E,
  output logic             S
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             busy_q, done_q, l_q, e_q, s_q;
`ifdef SEQ_COMP_SIGNED_EN
  logic             sm_q;
`endif

  logic [WIDTH-1:0] w_a_eff, w_b_eff;
  logic [CHUNK-1:0] w_sa, w_sb;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the slice compare itself never changes.
  always_comb begin
    w_a_eff = a_q;
    w_b_eff = b_q;
`ifdef SEQ_COMP_SIGNED_EN
    w_a_eff[WIDTH-1] = a_q[WIDTH-1] ^ sm_q;
    w_b_eff[WIDTH-1] = b_q[WIDTH-1] ^ sm_q;
`endif
    w_sa = '0;
    w_sb = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDXW'(i)) begin
        w_sa = w_a_eff[i*CHUNK +: CHUNK];
        w_sb = w_b_eff[i*CHUNK +: CHUNK];
      end
    end
  end

  assign idx_d = idx_q - IDXW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      s_q     <= 1'b0;
`ifdef SEQ_COMP_SIGNED_EN
      sm_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
`ifdef SEQ_COMP_SIGNED_EN
            sm_q    <= signed_mode;
`endif
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            s_q     <= 1'b0;
            idx_q   <= IDX_TOP;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (w_sa > w_sb) begin
            l_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (w_sa < w_sb) begin
            s_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (idx_q == '0) begin
            e_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign L    = l_q;
  assign E    = e_q;
  assign S    = s_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_comp.sv
`default_nettype none
// =============================================================================
// tb_seq_comp : directed self-checking bench for seq_comp (WIDTH=16, CHUNK=4).
// Rev 1.0 -- signed cases are compiled in only with SEQ_COMP_SIGNED_EN.
// =============================================================================
module tb_seq_comp;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        sm;
  logic        busy, done, L, E, S;

  int total = 0;
  int bad   = 0;

  seq_comp #(.WIDTH(16), .CHUNK(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
`ifdef SEQ_COMP_SIGNED_EN
    .signed_mode (sm),
`endif
    .busy        (busy),
    .done        (done),
    .L           (L),
    .E           (E),
    .S           (S)
  );

  always #5 clk = ~clk;

  // Issues one compare and reports the edge count (after the start edge) at
  // which done appeared, plus how many cycles broke the busy/result rules.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tsm, output int lat, output int viol);
    @(negedge clk);
    a = ta; b = tb_v; sm = tsm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = -1;
    viol = 0;
    if (!busy || done || L || E || S) viol++;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        if (busy) viol++;
        break;
      end else if (!busy || L || E || S) begin
        viol++;
      end
    end
  endtask

  task automatic check_result(input string name, input logic [15:0] ta,
                              input logic [15:0] tb_v, input logic tsm,
                              input int exp_lat, input logic [2:0] exp_les);
    int lat, viol;
    run_op(ta, tb_v, tsm, lat, viol);
    total++;
    if (lat !== exp_lat) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    total++;
    if ({L, E, S} !== exp_les) begin
      bad++; $display("FAIL %s LES: got %b want %b", name, {L, E, S}, exp_les);
    end
    total++;
    if (viol !== 0) begin
      bad++; $display("FAIL %s busy-phase: got %0d violations want 0", name, viol);
    end
    @(posedge clk); #1;
    total++;
    if ({busy, done, L, E, S} !== {2'b00, exp_les}) begin
      bad++; $display("FAIL %s hold: got busy/done/LES %b want %b", name,
                      {busy, done, L, E, S}, {2'b00, exp_les});
    end
    repeat (2) @(posedge clk); #1;
    total++;
    if ({busy, done, L, E, S} !== {2'b00, exp_les}) begin
      bad++; $display("FAIL %s hold-late: got %b want %b", name,
                      {busy, done, L, E, S}, {2'b00, exp_les});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 16'hFFFF; b = 16'h0000; sm = 1'b0;
    repeat (3) @(posedge clk); #1;
    total++;
    if ({busy, done, L, E, S} !== 5'b00000) begin
      bad++; $display("FAIL reset outputs: got %b want 00000", {busy, done, L, E, S});
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy, done, L, E, S} !== 5'b00000) begin
      bad++; $display("FAIL reset release: got %b want 00000", {busy, done, L, E, S});
    end
  endtask

  task automatic test_equal();
    check_result("equal_1234", 16'h1234, 16'h1234, 1'b0, 4, 3'b010);
  endtask

  task automatic test_early_exit();
    check_result("early_9000", 16'h9000, 16'h3FFF, 1'b0, 1, 3'b100);
    check_result("second_A0FF", 16'hA0FF, 16'hA1FF, 1'b0, 2, 3'b001);
  endtask

  task automatic test_low_slice();
    check_result("low_0002", 16'h0002, 16'h0007, 1'b0, 4, 3'b001);
    check_result("low_0E07", 16'h0E07, 16'h0E02, 1'b0, 4, 3'b100);
  endtask

  task automatic test_busy_start();
    int lat;
    int dones;
    @(negedge clk);
    a = 16'h1234; b = 16'h1235; sm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    a = 16'hF000; b = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = (done) ? 1 : -1;
    dones = (done) ? 1 : 0;
    for (int k = 2; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (lat < 0) lat = k;
      end
    end
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL busy_start latency: got %0d want 4", lat);
    end
    total++;
    if ({L, E, S} !== 3'b001) begin
      bad++; $display("FAIL busy_start LES: got %b want 001", {L, E, S});
    end
    total++;
    if (dones !== 1) begin
      bad++; $display("FAIL busy_start done count: got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    a = 16'h5555; b = 16'h5555; sm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL midrun busy before reset: got %b want 1", busy);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, L, E, S} !== 5'b00000) begin
      bad++; $display("FAIL midrun async reset: got %b want 00000", {busy, done, L, E, S});
    end
    @(negedge clk);
    rst = 1'b0;
    check_result("after_reset", 16'h9000, 16'h3FFF, 1'b0, 1, 3'b100);
  endtask

`ifdef SEQ_COMP_SIGNED_EN
  task automatic test_signed();
    check_result("signed_on", 16'hFFFF, 16'h0001, 1'b1, 1, 3'b001);
    check_result("signed_off", 16'hFFFF, 16'h0001, 1'b0, 1, 3'b100);
  endtask
`endif

  initial begin
    test_reset();
    test_equal();
    test_early_exit();
    test_low_slice();
    test_busy_start();
    test_reset_midrun();
`ifdef SEQ_COMP_SIGNED_EN
    test_signed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_comp.md
SEQ_COMP -- requirements
Module: seq_comp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, meaning bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports:
- clk  input  1  clock; rising edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to compare a and b.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- signed_mode  input  1  two's-complement compare; present only with SEQ_COMP_SIGNED_EN.
- busy  output  1  a compare is in progress.
- done  output  1  one-cycle pulse: result valid.
- L  output  1  A > B.
- E  output  1  A == B.
- S  output  1  A < B.

Function
REQ-004 The FSM SHALL have three states, IDLE, RUN and DONE, and SHALL reset to IDLE.
REQ-005 In IDLE with start=1 at a rising edge, the block SHALL capture a, b (and signed_mode), clear L/E/S to 0, set the chunk index to N-1, and go to RUN.
REQ-006 start SHALL be ignored in RUN and DONE; captured operands SHALL NOT change until the next accepted start.
REQ-007 Each RUN cycle SHALL compare one CHUNK-bit slice of the captured operands, MSB slice first, as unsigned values.
REQ-008 Early termination:
- If the slices differ, the block SHALL set L=1 (A slice greater) or S=1 (A slice smaller) and go to DONE.
- If the slices are equal and the index is 0, the block SHALL set E=1 and go to DONE.
- Otherwise the block SHALL decrement the index and stay in RUN.
REQ-009 Latency: if the first differing slice is the m-th from the top (m=1..N), or m=N for equal operands, done SHALL be high in the m-th cycle after the start edge.
REQ-010 busy SHALL be 1 exactly while in RUN.
REQ-011 done SHALL be 1 exactly while in DONE, for one cycle; DONE SHALL always return to IDLE.
REQ-012 After done, exactly one of L/E/S SHALL be 1, and it SHALL be held until the next accepted start or reset.
REQ-013 While busy, L, E and S SHALL all be 0.
REQ-014 N=1 (CHUNK=WIDTH) SHALL be legal and SHALL complete in one RUN cycle.

Reset
REQ-015 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, L=0, E=0, S=0, and clear the index and operand registers, including mid-RUN.
REQ-016 The block SHALL accept no start while rst=1; the first start sampled after rst deasserts SHALL be accepted normally.

Configuration
REQ-017 With macro SEQ_COMP_SIGNED_EN defined:
- The signed_mode port SHALL exist.
- When the captured signed_mode=1, the block SHALL invert bit WIDTH-1 of both operands before the top-slice compare, giving two's-complement ordering.
- The latency rules SHALL be unchanged.
REQ-018 Without SEQ_COMP_SIGNED_EN, the block SHALL have no signed_mode port and all compares SHALL be unsigned.

Verification (WIDTH=16, CHUNK=4)
REQ-019 a=b=16'h1234, start -> busy for 4 cycles, done in cycle 4, E=1, L=S=0, held afterwards.
REQ-020 a=16'h9000, b=16'h3FFF -> early exit: done in cycle 1, L=1, E=S=0.
REQ-021 a=16'h0002, b=16'h0007 -> done in cycle 4, S=1; a=16'h0E07, b=16'h0E02 -> done in cycle 4, L=1.
REQ-022 SEQ_COMP_SIGNED_EN, a=16'hFFFF, b=16'h0001: signed_mode=1 -> S=1 in cycle 1; signed_mode=0 -> L=1 in cycle 1.
REQ-023 Start pulse while busy (operands changed) -> ignored; the result reflects the first operands, and no second done occurs.
REQ-024 rst asserted in cycle 2 of RUN -> busy, done, L, E and S are 0 immediately; a new start after release completes normally.
